// File: rtl/arbiter_4x2_rr.sv
// ---------------------------------------------------------------------------
// arbiter_4x2_rr
// Four-requester arbiter with a one-hot grant plus a binary grant index.
// The policy is either round-robin or fixed priority (requester 0 highest).
// A grant is held until the holder signals done, drops its request, or the
// optional hold timer expires. Each grant is followed by one RELEASE cycle
// and one IDLE cycle before the next grant can be issued.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous reset, active high
//   req[3:0] in   request vector, one bit per requester
//   done     in   holder releases the resource (looked at only in GRANT)
//   gnt[3:0] out  one-hot grant
//   gnt_idx  out  binary index of the granted requester, 0 when no grant
//   gnt_vld  out  high exactly when gnt is nonzero
//   timeout  out  one-cycle pulse when a grant is revoked by the hold timer
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no grant; a nonzero req picks a winner at the next edge
// GRANT   | winner holds the resource; other req bits are ignored
// RELEASE | one dead cycle with no grant, then back to IDLE
// ---------------------------------------------------------------------------
module arbiter_4x2_rr #(
    parameter string DESCRIPTION = "RR",
    parameter int    MAX_HOLD    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Anything other than "RR" falls back to fixed priority.
    localparam bit         IS_RR      = (DESCRIPTION == "RR");
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = TIMEOUT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_gnt_idx;
    logic       r_gnt_vld;
    logic       r_timeout;
    logic [7:0] r_hold_cnt;
    logic [1:0] r_last;

    logic [1:0] w_win_idx;
    logic       w_release;
    logic       w_expire;

    // Winner search. RR scans last+1, last+2, ... with 2-bit wraparound;
    // fixed priority scans 0..3. The first requesting index wins.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        w_win_idx = 2'd0;
        found     = 1'b0;
        cand      = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = IS_RR ? (r_last + 2'(k + 1)) : 2'(k);
            if (!found && req[cand]) begin
                w_win_idx = cand;
                found     = 1'b1;
            end
        end
    end

    // In GRANT, r_gnt_idx is the holder index.
    assign w_release = done || !req[r_gnt_idx];
    assign w_expire  = TIMEOUT_EN && (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 4'd0;
            r_gnt_idx  <= 2'd0;
            r_gnt_vld  <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= 8'd0;
            r_last     <= 2'd3;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req != 4'd0) begin
                        r_state    <= ST_GRANT;
                        r_gnt      <= 4'b0001 << w_win_idx;
                        r_gnt_idx  <= w_win_idx;
                        r_gnt_vld  <= 1'b1;
                        r_hold_cnt <= 8'd0;
                    end
                end
                ST_GRANT: begin
                    if (w_release || w_expire) begin
                        r_state   <= ST_RELEASE;
                        r_gnt     <= 4'd0;
                        r_gnt_idx <= 2'd0;
                        r_gnt_vld <= 1'b0;
                        r_last    <= r_gnt_idx;
                        // A normal release on the expiry edge suppresses the pulse.
                        r_timeout <= !w_release;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign gnt_vld = r_gnt_vld;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_arbiter_4x2_rr.sv
module tb_arbiter_4x2_rr;

    localparam int MH_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [3:0] req_a, req_b, req_c;
    logic       done_a, done_b, done_c;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       vld_a, vld_b, vld_c;
    logic       to_a, to_b, to_c;

    arbiter_4x2_rr #(.DESCRIPTION("RR"), .MAX_HOLD(MH_A)) u_rr (
        .clk(clk), .rst(rst_a), .req(req_a), .done(done_a),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .timeout(to_a));

    arbiter_4x2_rr #(.DESCRIPTION("FIXED"), .MAX_HOLD(0)) u_fx (
        .clk(clk), .rst(rst_b), .req(req_b), .done(done_b),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .timeout(to_b));

    arbiter_4x2_rr #(.DESCRIPTION("RR"), .MAX_HOLD(2)) u_m2 (
        .clk(clk), .rst(rst_c), .req(req_c), .done(done_c),
        .gnt(gnt_c), .gnt_idx(idx_c), .gnt_vld(vld_c), .timeout(to_c));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output-consistency properties, checked every cycle on all instances.
    function automatic int inv_ok(input logic [3:0] g, input logic [1:0] i, input logic v);
        logic enc_ok;
        enc_ok = (g == 4'd0) ? (i == 2'd0) : (g == (4'b0001 << i));
        return ((g & (g - 4'd1)) == 4'd0) && (v == (g != 4'd0)) && enc_ok;
    endfunction

    always @(negedge clk) begin
        check("inv_rr", inv_ok(gnt_a, idx_a, vld_a), 1);
        check("inv_fx", inv_ok(gnt_b, idx_b, vld_b), 1);
        check("inv_m2", inv_ok(gnt_c, idx_c, vld_c), 1);
    end

    // Reference model for u_rr: tracks who holds the resource and for how
    // many cycles it has been held, rather than counter/state encodings.
    int m_phase;   // 0 free, 1 held, 2 cool-down
    int m_holder;
    int m_last;
    int m_held;    // number of cycles the grant has been visible so far
    int m_to;

    task automatic m_reset();
        m_phase = 0; m_holder = 0; m_last = 3; m_held = 0; m_to = 0;
    endtask

    task automatic m_edge(input logic [3:0] r, input logic d);
        m_to = 0;
        if (m_phase == 0) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_phase == 0 && r[(m_last + k) % 4]) begin
                    m_holder = (m_last + k) % 4;
                    m_phase  = 1;
                    m_held   = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (d || !r[m_holder]) begin
                m_phase = 2; m_last = m_holder;
            end else if (m_held == MH_A) begin
                m_phase = 2; m_last = m_holder; m_to = 1;
            end else begin
                m_held++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int n_to;
        tbl[0]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[1]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[2]  = '{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[9]  = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[10] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[11] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[12] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1};
        tbl[14] = '{4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[15] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = 4'd0; req_b = 4'd0; req_c = 4'd0;
        done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
        step(); step();
        check("rst_gnt", gnt_a, 0);
        check("rst_idx", idx_a, 0);
        check("rst_vld", vld_a, 0);
        check("rst_to",  to_a, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Table-driven sequence on u_rr starting from reset (last = 3).
        for (int i = 0; i < 16; i++) begin
            req_a  = tbl[i].req;
            done_a = tbl[i].done;
            step();
            check($sformatf("tbl%0d_gnt", i), gnt_a, tbl[i].gnt);
            check($sformatf("tbl%0d_idx", i), idx_a, tbl[i].idx);
            check($sformatf("tbl%0d_vld", i), vld_a, tbl[i].vld);
            check($sformatf("tbl%0d_to", i),  to_a,  tbl[i].to);
        end

        // Asynchronous reset mid-GRANT: outputs drop before the next edge.
        rst_a = 1'b1;
        #1;
        check("arst_gnt", gnt_a, 0);
        check("arst_vld", vld_a, 0);
        check("arst_to",  to_a, 0);
        req_a = 4'b1000;
        #1;
        rst_a = 1'b0;
        step();
        check("arst_resume_gnt", gnt_a, 4'b1000);
        check("arst_resume_to", to_a, 0);

        // RR fairness with all requesters active.
        rst_a = 1'b1; req_a = 4'b1111; done_a = 1'b0;
        #1; rst_a = 1'b0;
        for (int g = 0; g < 5; g++) begin
            step();
            check($sformatf("rr_idx%0d", g), idx_a, g % 4);
            check($sformatf("rr_vld%0d", g), vld_a, 1);
            done_a = 1'b1;
            step();
            check($sformatf("rr_gap1_%0d", g), vld_a, 0);
            check($sformatf("rr_gap1to_%0d", g), to_a, 0);
            done_a = 1'b0;
            step();
            check($sformatf("rr_gap2_%0d", g), vld_a, 0);
        end

        // Timeout with MAX_HOLD = 4.
        rst_a = 1'b1; req_a = 4'b0100; done_a = 1'b0;
        #1; rst_a = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("tmo_hold%0d", c), gnt_a, 4'b0100);
            check($sformatf("tmo_nopulse%0d", c), to_a, 0);
        end
        step();
        check("tmo_pulse", to_a, 1);
        check("tmo_pulse_gnt", gnt_a, 0);
        step();
        check("tmo_pulse_end", to_a, 0);
        check("tmo_idle_gnt", gnt_a, 0);
        step();
        check("tmo_regrant", gnt_a, 4'b0100);
        check("tmo_regrant_idx", idx_a, 2);

        // Release by request drop on the third grant cycle.
        rst_a = 1'b1; req_a = 4'b0010;
        #1; rst_a = 1'b0;
        step(); step(); step();
        check("drop_held", gnt_a, 4'b0010);
        req_a = 4'b1101;
        step();
        check("drop_rel_vld", vld_a, 0);
        check("drop_rel_to", to_a, 0);
        step();
        check("drop_idle_vld", vld_a, 0);
        step();
        check("drop_next_idx", idx_a, 2);

        // Fixed priority: requester 1 always beats requester 3.
        req_b = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            step();
            check($sformatf("fx_gnt%0d", g), gnt_b, 4'b0010);
            check($sformatf("fx_idx%0d", g), idx_b, 1);
            done_b = 1'b1;
            step();
            done_b = 1'b0;
            step();
            check($sformatf("fx_gap%0d", g), vld_b, 0);
        end
        // MAX_HOLD = 0: a grant is never revoked, even past hold_cnt wrap.
        n_to = 0;
        step();
        for (int c = 0; c < 300; c++) begin
            step();
            if (to_b) n_to++;
        end
        check("fx_no_timeout", n_to, 0);
        check("fx_long_hold", gnt_b, 4'b0010);

        // MAX_HOLD = 2: done on the expiry edge wins over the timeout.
        req_c = 4'b0001;
        step();
        check("m2_gnt", gnt_c, 4'b0001);
        step();
        check("m2_gnt2", gnt_c, 4'b0001);
        done_c = 1'b1;
        step();
        check("m2_done_rel", vld_c, 0);
        check("m2_done_noto", to_c, 0);
        done_c = 1'b0;
        step();
        step();
        check("m2_regrant", gnt_c, 4'b0001);
        step();
        check("m2_hold2", gnt_c, 4'b0001);
        step();
        check("m2_expire_to", to_c, 1);
        check("m2_expire_gnt", gnt_c, 0);

        // Randomized run of u_rr against the reference model.
        rst_a = 1'b1; req_a = 4'd0; done_a = 1'b0;
        m_reset();
        #1; rst_a = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 9) < 3) req_a = 4'($urandom);
            done_a = ($urandom_range(0, 4) == 0);
            step();
            m_edge(req_a, done_a);
            check("rnd_gnt", gnt_a, (m_phase == 1) ? (1 << m_holder) : 0);
            check("rnd_idx", idx_a, (m_phase == 1) ? m_holder : 0);
            check("rnd_vld", vld_a, (m_phase == 1) ? 1 : 0);
            check("rnd_to",  to_a,  m_to);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arbiter_4x2_rr.md
ARBITER_4X2_RR -- requirements
Module: arbiter_4x2_rr

Interface
REQ-001 Parameter DESCRIPTION, default "RR", SHALL select the arbitration policy: "RR" means round-robin; "FIXED" means fixed priority with req[0] highest; any other value SHALL behave as "FIXED".
REQ-002 Parameter MAX_HOLD, default 16, range 0..255, SHALL set the maximum number of cycles a grant is held; 0 disables the timeout.
REQ-003 clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 rst, input, 1: asynchronous, active-high reset.
REQ-005 req, input, 4: request vector, one bit per requester 0..3.
REQ-006 done, input, 1: current holder releases the resource; sampled only in GRANT.
REQ-007 gnt, output, 4: one-hot grant vector.
REQ-008 gnt_idx, output, 2: binary index of the granted requester (4x2 encoding of gnt).
REQ-009 gnt_vld, output, 1: high exactly when gnt is nonzero.
REQ-010 timeout, output, 1: single-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 The FSM SHALL have three states, IDLE, GRANT and RELEASE, all outputs registered.
REQ-012 In IDLE, if req != 0 at a rising edge, the arbiter SHALL select a winner and enter GRANT; gnt, gnt_idx and gnt_vld SHALL be valid from that edge (1-cycle latency from the sampled request).
REQ-013 In IDLE with req == 0, the arbiter SHALL remain in IDLE with gnt=0, gnt_idx=0, gnt_vld=0.
REQ-014 In RR mode, the search SHALL start at (last+1) mod 4 and wrap, where last is the index of the most recent holder; the first requesting index found wins.
REQ-015 In FIXED mode, the lowest requesting index SHALL win; last is ignored.
REQ-016 In GRANT, gnt, gnt_idx and the holder SHALL be stable; changes to other req bits SHALL have no effect.
REQ-017 hold_cnt (8 bits) SHALL be cleared on entry to GRANT and SHALL increment once per cycle spent in GRANT.
REQ-018 GRANT SHALL exit to RELEASE when done=1, or when req[holder]=0, whichever is sampled first.
REQ-019 If MAX_HOLD != 0, and hold_cnt == MAX_HOLD-1 while done=0 and req[holder]=1, the arbiter SHALL enter RELEASE and pulse timeout for exactly the cycle following that edge.
REQ-020 Release conditions SHALL take precedence over timeout: if done or req[holder]=0 coincides with expiry, timeout SHALL stay 0.
REQ-021 On every entry to RELEASE, last SHALL be updated to the holder index.
REQ-022 RELEASE SHALL last exactly one cycle with gnt=0 and gnt_vld=0, then go to IDLE unconditionally; the minimum idle gap between grants is 2 cycles.
REQ-023 gnt_idx SHALL hold 0 whenever gnt_vld=0.
REQ-024 At most one gnt bit SHALL be high in any cycle.

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, gnt=0, gnt_idx=0, gnt_vld=0, timeout=0, hold_cnt=0 and last=3, so that the first RR search starts at index 0.
REQ-026 Reset asserted during GRANT SHALL drop the grant without a timeout pulse; after reset deassertion, arbitration SHALL resume from IDLE on the next edge.

Verification
REQ-027 RR fairness: DESCRIPTION="RR", req=4'b1111 held, done pulsed one cycle after each grant -> gnt_idx sequence is 0,1,2,3,0, with each grant separated by 2 cycles of gnt_vld=0.
REQ-028 Fixed priority: DESCRIPTION="FIXED", req=4'b1010 held with done pulses -> every grant has gnt_idx=1 (gnt=4'b0010); requester 3 is never granted.
REQ-029 Timeout: MAX_HOLD=4, req=4'b0100 held, done=0 -> gnt=4'b0100 for exactly 4 cycles, then a 1-cycle timeout pulse coinciding with gnt=0, then a regrant to index 2 after IDLE.
REQ-030 Release via request drop: requester 1 granted, req[1] deasserted on the 3rd grant cycle -> RELEASE on the next edge, timeout=0, and last=1 (next RR search starts at 2).
REQ-031 Simultaneous events: MAX_HOLD=2, done=1 on the expiry edge -> RELEASE with timeout=0; mid-GRANT asynchronous rst -> all outputs 0 before the next clk edge.
REQ-032 All scenarios: a checker SHALL assert gnt one-hot or zero, gnt_vld==(gnt!=0), and gnt_idx equal to the encoded gnt in every cycle.
